// File: rtl/noc_packet_injector.sv
// -----------------------------------------------------------------------------
// noc_packet_injector
//
// Source-side packetizer for the local input port of a 2D-mesh NoC router.
// A packet request (destination + body length) is turned into one header flit
// carrying the first-hop routing direction, followed by `req_length` body
// flits taken from the data stream. Routers further along compute every later
// hop from the header routing field; only the first hop is computed here, using
// the same X-first-then-Y rule. Flow control toward the router is credit based.
//
// The file also holds package `noc`, which defines the coordinate and
// direction types shared with the router.
//
// Parameters
//   FlitWidth  flit payload width, excluding the head/tail preamble (>= 21 so
//              the header fields fit)
//   Credits    depth of the router local input buffer; credit counter reset value
//
// Ports
//   clk              clock
//   rst              asynchronous, active-low reset
//   position         this router's x,y coordinates (static after init)
//   req_valid/ready  packet request handshake
//   req_destination  destination x,y
//   req_length       number of body flits (0..255)
//   data_valid/ready body word handshake
//   data_in          body word
//   flit_valid       flit_out valid (never back-pressured)
//   flit_out         {head, tail, payload}
//   credit_in        one-cycle pulse per freed router buffer slot
//   drop_pulse       one-cycle pulse when a self-addressed request is dropped
//                    (only present when NOC_INJECTOR_LOOPBACK_EN is undefined)
//
// Configuration macro: NOC_INJECTOR_LOOPBACK_EN
//   defined   : destination == own position routes goLocal and is injected
//   undefined : such packets are accepted and swallowed (body words consumed,
//               nothing emitted, credits untouched, drop_pulse at the request)
// -----------------------------------------------------------------------------

package noc;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } xy_t;

  typedef enum logic [4:0] {
    goLocal = 5'b00001,
    goEast  = 5'b00010,
    goWest  = 5'b00100,
    goNorth = 5'b01000,
    goSouth = 5'b10000
  } direction_t;

endpackage

module noc_packet_injector #(
  parameter int FlitWidth = 64,
  parameter int Credits   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  noc::xy_t             position,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  noc::xy_t             req_destination,
  input  logic [7:0]           req_length,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [FlitWidth-1:0] data_in,
  output logic                 flit_valid,
  output logic [FlitWidth+1:0] flit_out,
  input  logic                 credit_in
`ifndef NOC_INJECTOR_LOOPBACK_EN
  ,
  output logic                 drop_pulse
`endif
);

  localparam int CW = $clog2(Credits + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHead = 2'd1;
  localparam logic [1:0] StBody = 2'd2;

  logic [1:0]           state;
  noc::xy_t             pos_q;
  noc::xy_t             dest_q;
  logic [7:0]           len_q;
  logic [7:0]           rem_q;
  logic [4:0]           route_q;
  logic                 drop_q;
  logic [CW-1:0]        credits_q;

  logic [4:0]           route;
  logic                 drop_now;
  logic                 req_fire;
  logic                 data_fire;
  logic                 have_credit;
  logic                 head_send;
  logic                 body_send;
  logic                 flit_send;
  logic [FlitWidth-1:0] header_payload;

  // Position is registered so routing sees it one cycle after it changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q <= '0;
    end else begin
      pos_q <= position;
    end
  end

  // First hop: resolve X completely before Y; equal coordinates stay local.
  always_comb begin
    route = noc::goLocal;
    if (pos_q.x > req_destination.x) begin
      route = noc::goWest;
    end else if (pos_q.x < req_destination.x) begin
      route = noc::goEast;
    end else if (pos_q.y > req_destination.y) begin
      route = noc::goNorth;
    end else if (pos_q.y < req_destination.y) begin
      route = noc::goSouth;
    end
  end

`ifdef NOC_INJECTOR_LOOPBACK_EN
  assign drop_now = 1'b0;
`else
  // Self-addressed packets would bounce straight back into this port, so they
  // are swallowed here instead of being injected.
  assign drop_now   = (req_destination == pos_q);
  assign drop_pulse = req_fire && drop_now;
`endif

  assign have_credit = (credits_q != '0);
  assign req_ready   = (state == StIdle);
  // A dropped packet still drains its body words but never needs a credit.
  assign data_ready  = (state == StBody) && (drop_q || have_credit);
  assign req_fire    = req_valid && req_ready;
  assign data_fire   = data_valid && data_ready;
  assign head_send   = (state == StHead) && !drop_q && have_credit;
  assign body_send   = data_fire && !drop_q;
  assign flit_send   = head_send || body_send;

  // Header payload: routing in the low bits, then destination, then source.
  always_comb begin
    header_payload        = '0;
    header_payload[4:0]   = route_q;
    header_payload[12:5]  = dest_q;
    header_payload[20:13] = pos_q;
  end

  // Packet sequencing: latch the request, emit the header, then count down
  // the body flits. rem_q holds the number of body flits still to send.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= StIdle;
      dest_q  <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      route_q <= noc::goLocal;
      drop_q  <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (req_fire) begin
            dest_q  <= req_destination;
            len_q   <= req_length;
            rem_q   <= req_length;
            route_q <= route;
            drop_q  <= drop_now;
            state   <= StHead;
          end
        end
        StHead: begin
          if (drop_q || have_credit) begin
            state <= (len_q == 8'd0) ? StIdle : StBody;
          end
        end
        StBody: begin
          if (data_fire) begin
            rem_q <= rem_q - 8'd1;
            if (rem_q == 8'd1) begin
              state <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Registered flit output; flit_out keeps its last value while not valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_valid <= 1'b0;
      flit_out   <= '0;
    end else begin
      flit_valid <= flit_send;
      if (head_send) begin
        flit_out <= {1'b1, (len_q == 8'd0), header_payload};
      end else if (body_send) begin
        flit_out <= {1'b0, (rem_q == 8'd1), data_in};
      end
    end
  end

  // Credit counter. A returned credit only becomes usable next cycle because
  // the send decision looks at the registered count. Returning a credit into
  // a full counter is an environment error and is ignored (saturates).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits_q <= CW'(Credits);
    end else begin
      case ({flit_send, credit_in})
        2'b10: credits_q <= credits_q - CW'(1);
        2'b01: begin
          if (credits_q != CW'(Credits)) begin
            credits_q <= credits_q + CW'(1);
          end
        end
        default: credits_q <= credits_q;
      endcase
    end
  end

endmodule
